serial_add_sub: RTL and testbench

Bit-serial adder/subtractor that consumes two W-bit operands through a start/done handshake and produces their sum or difference LSB-first, one bit per clock. The datapath is a single full adder built from two `half_adder_structural` instances. This block is the clocked, multi-cycle counterpart to the combinational adder cells. It serves as the sequential arithmetic unit for designs that trade latency for area.

---
 rtl/serial_arith_pkg.sv | 12 +
 rtl/full_adder_structural.sv | 30 +++
 rtl/half_adder_structural.sv | 12 +
 rtl/serial_add_sub.sv | 106 ++++++++++
 tb/tb_serial_add_sub.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/serial_arith_pkg.sv
// Shared types and defaults for the bit-serial arithmetic unit.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sas_state_t;

  localparam int W_DEFAULT = 8;

endpackage

// File: rtl/full_adder_structural.sv
// Full adder composed of two half adders plus an OR for the carry.
module full_adder_structural (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic s1;
  logic c1;
  logic c2;

  half_adder_structural u_ha0 (
    .a (x),
    .b (y),
    .s (s1),
    .c (c1)
  );

  half_adder_structural u_ha1 (
    .a (s1),
    .b (cin),
    .s (s),
    .c (c2)
  );

  assign cout = c1 | c2;

endmodule

// File: rtl/half_adder_structural.sv
// Gate-level half adder; building block for the full adder cell.
module half_adder_structural (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one result bit per clock, LSB first, with a
// start/done handshake. Subtraction is a + ~b + 1 through the same adder.
//
//   state | meaning
//   IDLE  | waiting for start
//   RUN   | one operand bit pair per cycle, W cycles
//   DONE  | one-cycle done pulse; start here chains the next op
module serial_add_sub
  import serial_arith_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         cout
);

  localparam int CW = $clog2(W) + 1;

  sas_state_t    state;
  sas_state_t    state_next;
  logic          accept;
  logic          last;
  logic [W-1:0]  sa;
  logic [W-1:0]  sb;
  logic          carry;
  logic [CW-1:0] cnt;
  logic          fa_s;
  logic          fa_c;

  full_adder_structural u_fa (
    .x    (sa[0]),
    .y    (sb[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_c)
  );

  assign last = (cnt == CW'(W - 1));

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (last) state_next = DONE;
      end
      DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sa     <= '0;
      sb     <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      result <= '0;
      cout   <= 1'b0;
    end else if (accept) begin
      sa     <= a;
      sb     <= sub ? ~b : b;
      carry  <= sub;
      cnt    <= '0;
      result <= '0;
    end else if (state == RUN) begin
      sa     <= sa >> 1;
      sb     <= sb >> 1;
      carry  <= fa_c;
      cnt    <= cnt + CW'(1);
      result <= {fa_s, result[W-1:1]};
      // cout keeps the previous op's value until the final bit produces a new one
      if (last) cout <= fa_c;
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_add_sub.sv
// Self-checking bench for serial_add_sub (W=4): timeline/arithmetic model
// checked every cycle, plus directed cases with literal expectations.
module tb_serial_add_sub;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;

  int checks = 0;
  int errors = 0;

  serial_add_sub #(.W(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .sub    (sub),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Model: phase = edges since the accepting edge (-1 when idle).
  // Phases 0..W-1 are busy, phase W is the done cycle.
  int       phase = -1;
  bit       hold_valid = 1'b0;
  int       hold_res = 0;
  int       hold_cout = 0;
  int       pend_res = 0;
  int       pend_cout = 0;

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        phase      = -1;
        hold_valid = 1'b1;
        hold_res   = 0;
        hold_cout  = 0;
      end else if ((phase == -1 || phase == W) && start) begin
        phase      = 0;
        hold_valid = 1'b0;
        if (sub) begin
          pend_res  = (int'(a) - int'(b)) & ((1 << W) - 1);
          pend_cout = (a >= b) ? 1 : 0;
        end else begin
          pend_res  = (int'(a) + int'(b)) & ((1 << W) - 1);
          pend_cout = ((int'(a) + int'(b)) >= (1 << W)) ? 1 : 0;
        end
      end else if (phase >= 0 && phase < W) begin
        phase = phase + 1;
        if (phase == W) begin
          hold_valid = 1'b1;
          hold_res   = pend_res;
          hold_cout  = pend_cout;
        end
      end else if (phase == W) begin
        phase = -1;
      end
      #1;
      check("busy", int'(busy), (phase >= 0 && phase < W) ? 1 : 0);
      check("done", int'(done), (phase == W) ? 1 : 0);
      if (busy && done) begin
        errors++;
        $display("FAIL busy_done_overlap at %0t: got both high expected exclusive", $time);
      end
      if (hold_valid) begin
        check("result", int'(result), hold_res);
        check("cout", int'(cout), hold_cout);
      end
    end
  end

  // Starts one op and waits for done; returns negedges from start to done.
  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic isub,
                        input int exp_res, input int exp_cout, input string name);
    int n;
    @(negedge clk);
    start = 1'b1; a = ia; b = ib; sub = isub;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({name, "_latency"}, n, W + 1);
    check({name, "_result"}, int'(result), exp_res);
    check({name, "_cout"}, int'(cout), exp_cout);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_result", int'(result), 0);
    check("reset_cout", int'(cout), 0);

    run_op(4'd3,  4'd5, 1'b0, 8,  0, "add_3_5");
    run_op(4'd15, 4'd1, 1'b0, 0,  1, "add_15_1");
    run_op(4'd0,  4'd0, 1'b0, 0,  0, "add_0_0");
    run_op(4'd5,  4'd3, 1'b1, 2,  1, "sub_5_3");
    run_op(4'd7,  4'd7, 1'b1, 0,  1, "sub_7_7");
    run_op(4'd3,  4'd5, 1'b1, 14, 0, "sub_3_5");

    // start during RUN is ignored
    @(negedge clk);
    start = 1'b1; a = 4'd9; b = 4'd4; sub = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; a = 4'd1; b = 4'd1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    check("ignore_start_done", int'(done), 1);
    check("ignore_start_result", int'(result), 13);
    check("ignore_start_cout", int'(cout), 0);

    // chained start in the DONE cycle
    start = 1'b1; a = 4'd2; b = 4'd2; sub = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("chain_busy", int'(busy), 1);
    n = 1;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("chain_latency", n, W + 1);
    check("chain_result", int'(result), 4);
    check("chain_cout", int'(cout), 0);

    // reset mid-op
    @(negedge clk);
    start = 1'b1; a = 4'd9; b = 4'd9; sub = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_result", int'(result), 0);
    check("abort_cout", int'(cout), 0);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) n++;
    end
    check("abort_no_done", n, 0);
    run_op(4'd6, 4'd7, 1'b0, 13, 0, "add_6_7");

    // randomized traffic, including starts while busy and occasional resets
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) == 0);
      a     = W'($urandom);
      b     = W'($urandom);
      sub   = 1'($urandom);
      rst   = ($urandom_range(0, 60) == 0);
    end
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b0;
    repeat (W + 3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
